cache_port_arbiter: RTL
=======================

Name: cache_port_arbiter

Overview:
- Shares the single cache controller (one-transaction-at-a-time, 16-bit address/data) between the instruction-fetch port (read-only) and the data port (read/write).
- Grants one requester, then holds the controller's address, data and op lines stable until the controller signals done or error.
- Returns each result to the owning port through a registered done pulse.
- Sits between the fetch/memory pipeline stages and the cache controller.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits before fetch is forced in (1..15).
- TIMEOUT, 255: cycles in BUSY without c_done/c_err before abort (1..255; counter width 8).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- i_rd  in  1  fetch read request, held until i_done
- i_addr  in  16  fetch address
- i_done  out  1  one-cycle fetch completion pulse
- i_data_out  out  16  fetch read data, valid with i_done
- i_hit  out  1  cache hit flag, valid with i_done
- d_rd  in  1  data read request, held until d_done
- d_wr  in  1  data write request, held until d_done
- d_addr  in  16  data address
- d_data_in  in  16  data write value
- d_done  out  1  one-cycle data completion pulse
- d_data_out  out  16  data read result, valid with d_done
- d_hit  out  1  cache hit flag, valid with d_done
- c_addr  out  16  controller address
- c_data_in  out  16  controller write data
- c_rd  out  1  controller read strobe
- c_wr  out  1  controller write strobe
- c_data_out  in  16  controller read data
- c_done  in  1  controller completion
- c_hit  in  1  controller hit flag, valid with c_done
- c_err  in  1  controller error
- err  out  1  one-cycle pulse: protocol error, c_err, or timeout
- owner  out  1  0 = fetch, 1 = data; valid while busy
- busy  out  1  high in BUSY

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State := IDLE; all outputs 0.
  - Starve counter and timeout counter := 0; hold registers := 0.
  - Reset mid-transaction abandons the op: no done pulse is issued.
- States:
  - IDLE: evaluates requests.
  - BUSY: transaction in flight.
  - TURN: one-cycle turnaround so the controller returns to its idle state.
- IDLE arbitration:
  - Data request valid = d_rd ^ d_wr.
  - If d_rd & d_wr: err pulses next cycle, data is not granted; fetch may be granted the same cycle.
  - Data has priority, except fetch wins when i_rd=1 and starve counter == STARVE_LIMIT.
  - On any grant:
    - Register addr, data (0 for fetch), op and owner into hold registers.
    - Go to BUSY next cycle.
    - Fetch grant clears the starve counter.
    - Data grant with i_rd=1 increments the starve counter, saturating.
    - Data grant with i_rd=0 clears the starve counter.
- BUSY:
  - c_addr, c_data_in, c_rd, c_wr come from the hold registers and stay constant for the whole state.
  - Requester inputs are ignored.
  - Timeout counter increments every cycle.
  - On c_done (checked before c_err):
    - Next cycle, owner's done = 1 and its data_out/hit := c_data_out/c_hit.
    - Go to TURN.
  - Else on c_err, or timeout counter reaching TIMEOUT:
    - Next cycle, err = 1 and owner's done = 1 with data_out = 0, hit = 0.
    - Go to TURN.
- TURN:
  - c_rd = c_wr = 0; timeout counter := 0.
  - Go to IDLE, so re-arbitration happens the following cycle.
  - The finishing requester must drop its request in the done cycle; a still-high request is treated as a new request.
- Latency:
  - Grant to c_rd/c_wr asserted: 1 cycle.
  - c_done to requester done: 1 cycle.
  - Minimum request-to-done: 3 cycles plus controller latency.
  - Back-to-back transactions are separated by at least 2 cycles (TURN + IDLE).
- Output rules:
  - data_out/hit outputs hold their last value between done pulses.
  - done and err are single-cycle pulses.
  - Only one of i_done/d_done may be high in any cycle.

Test Plan:
- Fetch-only read: i_rd=1, i_addr=0x1234; controller returns c_done after 4 BUSY cycles with c_data_out=0xBEEF, c_hit=1 -> c_addr=0x1234, c_rd=1 held every BUSY cycle; i_done=1, i_data_out=0xBEEF, i_hit=1 one cycle after c_done; c_rd=0 in TURN.
- Contention: d_wr=1 (d_addr=0x0040, d_data_in=0x5A5A) and i_rd=1 in the same cycle -> data granted first (owner=1, c_wr=1, c_data_in=0x5A5A); fetch is granted at the next IDLE.
- Starvation: d_rd held continuously with i_rd=1 and STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data again.
- Timeout: grant a data read and never assert c_done, TIMEOUT=8 -> after 8 BUSY cycles, err=1 and d_done=1 with d_data_out=0x0000 in the same cycle; then IDLE.
- Protocol error and reset: d_rd=d_wr=1 alone -> err pulses, no grant, c_rd=c_wr=0. Separately, rst_n=0 mid-BUSY -> all outputs 0 next cycle and no done pulse.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the cache controller.
// master = arbiter view, slave = requester/controller (environment) view.
interface cache_port_arbiter_if;
    logic        i_rd;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_data_out;
    logic        i_hit;

    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_data_in;
    logic        d_done;
    logic [15:0] d_data_out;
    logic        d_hit;

    logic [15:0] c_addr;
    logic [15:0] c_data_in;
    logic        c_rd;
    logic        c_wr;
    logic [15:0] c_data_out;
    logic        c_done;
    logic        c_hit;
    logic        c_err;

    logic        err;
    logic        owner;
    logic        busy;

    modport master (
        input  i_rd, i_addr,
        output i_done, i_data_out, i_hit,
        input  d_rd, d_wr, d_addr, d_data_in,
        output d_done, d_data_out, d_hit,
        output c_addr, c_data_in, c_rd, c_wr,
        input  c_data_out, c_done, c_hit, c_err,
        output err, owner, busy
    );

    modport slave (
        output i_rd, i_addr,
        input  i_done, i_data_out, i_hit,
        output d_rd, d_wr, d_addr, d_data_in,
        input  d_done, d_data_out, d_hit,
        input  c_addr, c_data_in, c_rd, c_wr,
        output c_data_out, c_done, c_hit, c_err,
        input  err, owner, busy
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Arbitrates the single cache controller between the fetch port (read-only)
// and the data port (read/write).
// Ports: clk, rst_n (sync active-low), bus (master modport: fetch req/resp,
// data req/resp, controller strobes/result, err/owner/busy status).
module cache_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_TURN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_starve;
    logic [7:0]  r_tmo;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_op_rd;
    logic        r_op_wr;
    logic        r_owner;

    logic        r_i_done;
    logic [15:0] r_i_data;
    logic        r_i_hit;
    logic        r_d_done;
    logic [15:0] r_d_data;
    logic        r_d_hit;
    logic        r_err;

    logic        w_idle;
    logic        w_busy;
    logic        w_d_req;
    logic        w_perr;
    logic        w_force_i;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_tmo_hit;
    logic        w_fin_ok;
    logic        w_fin_bad;

    assign w_idle    = (r_state == S_IDLE);
    assign w_busy    = (r_state == S_BUSY);
    assign w_d_req   = bus.d_rd ^ bus.d_wr;
    assign w_perr    = w_idle && bus.d_rd && bus.d_wr;
    // Fetch overrides data once it has lost STARVE_LIMIT grants in a row.
    assign w_force_i = bus.i_rd && (r_starve == 4'(STARVE_LIMIT));
    assign w_grant_d = w_idle && w_d_req && !w_force_i;
    assign w_grant_i = w_idle && bus.i_rd && !w_grant_d;
    // Counter holds the number of BUSY cycles already completed.
    assign w_tmo_hit = w_busy && (r_tmo == 8'(TIMEOUT - 1));
    assign w_fin_ok  = w_busy && bus.c_done;
    assign w_fin_bad = w_busy && !bus.c_done && (bus.c_err || w_tmo_hit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant_i || w_grant_d) w_next = S_BUSY;
            S_BUSY:  if (w_fin_ok || w_fin_bad) w_next = S_TURN;
            S_TURN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = w_busy;
        bus.owner      = r_owner;
        bus.c_addr     = r_addr;
        bus.c_data_in  = r_wdata;
        bus.c_rd       = w_busy && r_op_rd;
        bus.c_wr       = w_busy && r_op_wr;
        bus.i_done     = r_i_done;
        bus.i_data_out = r_i_data;
        bus.i_hit      = r_i_hit;
        bus.d_done     = r_d_done;
        bus.d_data_out = r_d_data;
        bus.d_hit      = r_d_hit;
        bus.err        = r_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_tmo    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_op_rd  <= 1'b0;
            r_op_wr  <= 1'b0;
            r_owner  <= 1'b0;
            r_i_done <= 1'b0;
            r_i_data <= '0;
            r_i_hit  <= 1'b0;
            r_d_done <= 1'b0;
            r_d_data <= '0;
            r_d_hit  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_err    <= w_perr;

            if (w_grant_d) begin
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_data_in;
                r_op_rd <= bus.d_rd;
                r_op_wr <= bus.d_wr;
                r_owner <= 1'b1;
                if (!bus.i_rd) begin
                    r_starve <= '0;
                end else if (r_starve != 4'(STARVE_LIMIT)) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else if (w_grant_i) begin
                r_addr   <= bus.i_addr;
                r_wdata  <= '0;
                r_op_rd  <= 1'b1;
                r_op_wr  <= 1'b0;
                r_owner  <= 1'b0;
                r_starve <= '0;
            end

            if (w_busy) begin
                r_tmo <= r_tmo + 8'd1;
            end else begin
                r_tmo <= '0;
            end

            if (w_fin_ok) begin
                if (r_owner) begin
                    r_d_done <= 1'b1;
                    r_d_data <= bus.c_data_out;
                    r_d_hit  <= bus.c_hit;
                end else begin
                    r_i_done <= 1'b1;
                    r_i_data <= bus.c_data_out;
                    r_i_hit  <= bus.c_hit;
                end
            end else if (w_fin_bad) begin
                // Abort: owner still gets a done so it can drop its request.
                r_err <= 1'b1;
                if (r_owner) begin
                    r_d_done <= 1'b1;
                    r_d_data <= '0;
                    r_d_hit  <= 1'b0;
                end else begin
                    r_i_done <= 1'b1;
                    r_i_data <= '0;
                    r_i_hit  <= 1'b0;
                end
            end
        end
    end

endmodule
